// File: rtl/writeback_pkg.sv
// Shared types for the requantize write-back path: the FIFO entry that
// carries a finished int8 result with its precomputed SRAM address, and
// the layer sequencing states.
package writeback_pkg;

   // SRAM address width; the entry struct is sized from it.
   localparam int WB_ADDR_W = 16;

   typedef logic signed [7:0] int8_t;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      int8_t                data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } wb_state_t;

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane synchronous FIFO of write-back entries. A push while full is
// still accepted when a pop happens in the same cycle, because the pop
// frees the slot the push lands in.
module wb_lane_fifo
   import writeback_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  wb_entry_t        push_entry_i,
   input  logic             pop_i,
   output wb_entry_t        head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             wr_en;
   logic             rd_en;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rptr_q];
   assign rd_en   = pop_i && !empty_o;
   assign wr_en   = push_i && (!full_o || pop_i);

   // Entry storage; contents need no reset since count gates all reads.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wptr_q] <= push_entry_i;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at a power-of-two depth.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + 1'b1;
         if (rd_en) rptr_q <= rptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/requant_writeback_arbiter.sv
// Collects int8 results from the requantize lanes into per-lane FIFOs,
// round-robins them onto the single SRAM write port through a registered
// output stage, and sequences a layer from start to done.
// Write port handshake: a write transfers on a rising edge where
// mem_we=1 and mem_ready=1; while mem_we=1 and mem_ready=0 the address
// and data are held unchanged.
module requant_writeback_arbiter
   import writeback_pkg::*;
#(
   parameter int SA_N       = 4,
   parameter int MAX_N      = 64,
   parameter int N_BITS     = $clog2(MAX_N),
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         drain,
   input  logic [WB_ADDR_W-1:0]         cfg_base_addr,
   input  logic [WB_ADDR_W-1:0]         cfg_row_stride,
   input  logic [WB_ADDR_W-1:0]         cfg_col_stride,
   input  logic [SA_N-1:0]              in_valid,
   input  logic [SA_N-1:0][N_BITS-1:0]  in_row,
   input  logic [SA_N-1:0][N_BITS-1:0]  in_col,
   input  logic [SA_N-1:0][7:0]         in_data,
   output logic                         mem_we,
   output logic [WB_ADDR_W-1:0]         mem_addr,
   output logic [7:0]                   mem_wdata,
   input  logic                         mem_ready,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow
);

   localparam int ADDR_W = WB_ADDR_W;
   localparam int LANE_W = (SA_N > 1) ? $clog2(SA_N) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   wb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] base_q, row_stride_q, col_stride_q;
   logic [LANE_W-1:0] rr_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;
   logic              overflow_q;

   wb_entry_t         push_entry [SA_N];
   wb_entry_t         fifo_head  [SA_N];
   logic [CNT_W-1:0]  fifo_count [SA_N];
   logic [SA_N-1:0]   push_en, fifo_pop, fifo_full, fifo_empty, ovf_hit;
   logic              layer_active, start_acc, stage_free, fifos_idle;
   logic              grant_valid;
   logic [LANE_W-1:0] grant_lane, cand;

   assign layer_active = (state_q == RUN) || (state_q == FLUSH);
   assign start_acc    = (state_q == IDLE) && start;
   assign stage_free   = !mem_we_q || mem_ready;

   // Address generation at push time plus push gating and overflow detect.
   always_comb begin
      fifos_idle = 1'b1;
      for (int k = 0; k < SA_N; k++) begin
         push_entry[k].addr = base_q
                            + ADDR_W'(in_row[k]) * row_stride_q
                            + ADDR_W'(in_col[k]) * col_stride_q
                            + ADDR_W'(k);
         push_entry[k].data = in_data[k];
         push_en[k]         = in_valid[k] && layer_active;
         ovf_hit[k]         = push_en[k] && fifo_full[k] && !fifo_pop[k];
         fifo_pop[k]        = grant_valid && (grant_lane == LANE_W'(k));
         if (fifo_count[k] != '0) fifos_idle = 1'b0;
      end
   end

   for (genvar k = 0; k < SA_N; k++) begin : g_lane
      wb_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk_i        (clk),
         .reset_i      (reset),
         .push_i       (push_en[k]),
         .push_entry_i (push_entry[k]),
         .pop_i        (fifo_pop[k]),
         .head_o       (fifo_head[k]),
         .full_o       (fifo_full[k]),
         .empty_o      (fifo_empty[k]),
         .count_o      (fifo_count[k])
      );
   end

   // Round-robin search from the pointer; grant only when the stage can load.
   always_comb begin
      grant_valid = 1'b0;
      grant_lane  = '0;
      cand        = '0;
      for (int i = 0; i < SA_N; i++) begin
         cand = LANE_W'((int'(rr_q) + i) % SA_N);
         if (!grant_valid && !fifo_empty[cand]) begin
            grant_valid = 1'b1;
            grant_lane  = cand;
         end
      end
      if (!stage_free) grant_valid = 1'b0;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; FLUSH ends once nothing is queued or still on the port.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (drain) state_d = FLUSH;
         FLUSH:   if (fifos_idle && stage_free) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   // Layer configuration and sticky overflow, both renewed by an accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q       <= '0;
         row_stride_q <= '0;
         col_stride_q <= '0;
         overflow_q   <= 1'b0;
      end else if (start_acc) begin
         base_q       <= cfg_base_addr;
         row_stride_q <= cfg_row_stride;
         col_stride_q <= cfg_col_stride;
         overflow_q   <= 1'b0;
      end else if (|ovf_hit) begin
         overflow_q   <= 1'b1;
      end
   end

   // Registered write stage and round-robin pointer update.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rr_q        <= '0;
      end else if (grant_valid) begin
         mem_we_q    <= 1'b1;
         mem_addr_q  <= fifo_head[grant_lane].addr;
         mem_wdata_q <= fifo_head[grant_lane].data;
         rr_q        <= (grant_lane == LANE_W'(SA_N - 1)) ? '0 : grant_lane + 1'b1;
      end else if (mem_ready) begin
         mem_we_q    <= 1'b0;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_requant_writeback_arbiter.sv
// Directed bench for requant_writeback_arbiter: one task per scenario,
// hand-computed expected values, inline comparisons.
module tb_requant_writeback_arbiter;

   logic              clk = 1'b0;
   logic              reset, start, drain, mem_ready;
   logic [15:0]       cfg_base_addr, cfg_row_stride, cfg_col_stride;
   logic [3:0]        in_valid;
   logic [3:0][5:0]   in_row, in_col;
   logic [3:0][7:0]   in_data;
   logic              mem_we, busy, done, overflow;
   logic [15:0]       mem_addr;
   logic [7:0]        mem_wdata;

   int tests_run    = 0;
   int tests_failed = 0;

   requant_writeback_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .drain          (drain),
      .cfg_base_addr  (cfg_base_addr),
      .cfg_row_stride (cfg_row_stride),
      .cfg_col_stride (cfg_col_stride),
      .in_valid       (in_valid),
      .in_row         (in_row),
      .in_col         (in_col),
      .in_data        (in_data),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ready      (mem_ready),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Starts a layer, then scrambles cfg_* to show it was latched.
   task automatic do_start(input logic [15:0] base, input logic [15:0] rs,
                           input logic [15:0] cs);
      cfg_base_addr  = base;
      cfg_row_stride = rs;
      cfg_col_stride = cs;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_base_addr  = 16'(($urandom_range(0, 65535)));
      cfg_row_stride = 16'(($urandom_range(0, 65535)));
      cfg_col_stride = 16'(($urandom_range(0, 65535)));
   endtask

   task automatic push_lane(input int lane, input logic [5:0] row,
                            input logic [5:0] col, input logic [7:0] data);
      in_valid[lane] = 1'b1;
      in_row[lane]   = row;
      in_col[lane]   = col;
      in_data[lane]  = data;
   endtask

   task automatic clear_push();
      in_valid = '0;
   endtask

   // Raises drain and waits (bounded) for the done pulse, then back to IDLE.
   task automatic finish_layer(input string name);
      bit seen = 1'b0;
      drain = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      drain = 1'b0;
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL %s_done_timeout: done not seen within 20 cycles, required a done pulse", name);
      end
      tick();
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({mem_we, busy, done, overflow} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: we/busy/done/ovf=%b, required 0000", {mem_we, busy, done, overflow});
      end
      tests_run++;
      if (mem_addr !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_addr: got %h, required 0000", mem_addr);
      end
      tests_run++;
      if (mem_wdata !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_wdata: got %h, required 00", mem_wdata);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_write();
      mem_ready = 1'b1;
      do_reset();
      do_start(16'h0100, 16'd32, 16'd4);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_busy: got %b, required 1", busy);
      end
      push_lane(2, 6'd1, 6'd3, 8'hFB);
      tick();
      clear_push();
      tests_run++;
      if (mem_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_early: mem_we=%b one edge after push, required 0", mem_we);
      end
      tick();
      tests_run++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h012E || mem_wdata !== 8'hFB) begin
         tests_failed++;
         $display("FAIL single_write: we=%b addr=%h data=%h, required we=1 addr=012e data=fb",
                  mem_we, mem_addr, mem_wdata);
      end
      tick();
      tests_run++;
      if (mem_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_once: mem_we=%b after the write, required 0", mem_we);
      end
      // Pointer now sits at lane 3, so lane 3 beats lane 0.
      push_lane(0, 6'd0, 6'd0, 8'h11);
      push_lane(3, 6'd0, 6'd0, 8'h33);
      tick();
      clear_push();
      tick();
      tests_run++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0103 || mem_wdata !== 8'h33) begin
         tests_failed++;
         $display("FAIL rr_from3_first: we=%b addr=%h data=%h, required we=1 addr=0103 data=33",
                  mem_we, mem_addr, mem_wdata);
      end
      tick();
      tests_run++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 8'h11) begin
         tests_failed++;
         $display("FAIL rr_from3_second: we=%b addr=%h data=%h, required we=1 addr=0100 data=11",
                  mem_we, mem_addr, mem_wdata);
      end
      finish_layer("single");
   endtask

   task automatic test_round_robin();
      logic [15:0] exp_a;
      logic [7:0]  exp_d;
      mem_ready = 1'b1;
      do_reset();
      do_start(16'h0200, 16'd16, 16'd1);
      for (int l = 0; l < 4; l++) push_lane(l, 6'd0, 6'd0, 8'(8'h10 + l));
      tick();
      clear_push();
      for (int l = 0; l < 4; l++) begin
         tick();
         exp_a = 16'(16'h0200 + l);
         exp_d = 8'(8'h10 + l);
         tests_run++;
         if (mem_we !== 1'b1 || mem_addr !== exp_a || mem_wdata !== exp_d) begin
            tests_failed++;
            $display("FAIL rr_lane%0d: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                     l, mem_we, mem_addr, mem_wdata, exp_a, exp_d);
         end
      end
      push_lane(0, 6'd2, 6'd1, 8'h20);
      push_lane(3, 6'd0, 6'd5, 8'h23);
      tick();
      clear_push();
      tests_run++;
      if (mem_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL rr_gap: mem_we=%b, required 0", mem_we);
      end
      tick();
      tests_run++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0221 || mem_wdata !== 8'h20) begin
         tests_failed++;
         $display("FAIL rr_wrap_lane0: we=%b addr=%h data=%h, required we=1 addr=0221 data=20",
                  mem_we, mem_addr, mem_wdata);
      end
      tick();
      tests_run++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0208 || mem_wdata !== 8'h23) begin
         tests_failed++;
         $display("FAIL rr_wrap_lane3: we=%b addr=%h data=%h, required we=1 addr=0208 data=23",
                  mem_we, mem_addr, mem_wdata);
      end
      finish_layer("rr");
   endtask

   task automatic test_backpressure();
      mem_ready = 1'b1;
      do_reset();
      do_start(16'h0300, 16'd0, 16'd0);
      mem_ready = 1'b0;
      push_lane(0, 6'd0, 6'd0, 8'hA1);
      push_lane(1, 6'd0, 6'd0, 8'hB2);
      tick();
      clear_push();
      for (int c = 0; c < 5; c++) begin
         tick();
         tests_run++;
         if (mem_we !== 1'b1 || mem_addr !== 16'h0300 || mem_wdata !== 8'hA1) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: we=%b addr=%h data=%h, required we=1 addr=0300 data=a1",
                     c, mem_we, mem_addr, mem_wdata);
         end
      end
      mem_ready = 1'b1;
      tick();
      tests_run++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0301 || mem_wdata !== 8'hB2) begin
         tests_failed++;
         $display("FAIL bp_next: we=%b addr=%h data=%h, required we=1 addr=0301 data=b2",
                  mem_we, mem_addr, mem_wdata);
      end
      tick();
      tests_run++;
      if (mem_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_idle: mem_we=%b, required 0", mem_we);
      end
      finish_layer("bp");
   endtask

   task automatic test_overflow();
      logic [7:0] got_q[$];
      logic [7:0] exp_q[$];
      logic       exp_ovf;
      mem_ready = 1'b1;
      do_reset();
      do_start(16'h0400, 16'd0, 16'd0);
      mem_ready = 1'b0;
      // Lane 0 occupies the stalled write stage first.
      push_lane(0, 6'd0, 6'd0, 8'h55);
      tick();
      clear_push();
      for (int i = 0; i < 6; i++) begin
         push_lane(1, 6'd0, 6'd0, 8'(8'h30 + i));
         tick();
         exp_ovf = (i >= 4);
         tests_run++;
         if (overflow !== exp_ovf) begin
            tests_failed++;
            $display("FAIL ovf_push%0d: overflow=%b, required %b", i + 1, overflow, exp_ovf);
         end
      end
      clear_push();
      exp_q = '{8'h55, 8'h30, 8'h31, 8'h32, 8'h33};
      mem_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (mem_we === 1'b1) got_q.push_back(mem_wdata);
         tick();
      end
      tests_run++;
      if (got_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL ovf_write_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests_run++;
         if (got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL ovf_write%0d: data=%h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      finish_layer("ovf");
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_sticky: overflow=%b in IDLE, required 1", overflow);
      end
      do_start(16'h0000, 16'd0, 16'd0);
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_clear_on_start: overflow=%b, required 0", overflow);
      end
   endtask

   task automatic test_drain_done();
      logic [15:0] exp_a;
      mem_ready = 1'b1;
      do_reset();
      do_start(16'h0500, 16'h0010, 16'h0001);
      for (int l = 0; l < 3; l++) push_lane(l, 6'd1, 6'd2, 8'(8'h60 + l));
      tick();
      clear_push();
      drain = 1'b1;
      for (int l = 0; l < 3; l++) begin
         tick();
         exp_a = 16'(16'h0512 + l);
         tests_run++;
         if (mem_we !== 1'b1 || mem_addr !== exp_a || mem_wdata !== 8'(8'h60 + l) || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_write%0d: we=%b addr=%h data=%h done=%b, required we=1 addr=%h data=%h done=0",
                     l, mem_we, mem_addr, mem_wdata, done, exp_a, 8'(8'h60 + l));
         end
      end
      drain = 1'b0;
      tick();
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_done: done=%b busy=%b we=%b, required done=1 busy=1 we=0", done, busy, mem_we);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_idle: done=%b busy=%b, required done=0 busy=0", done, busy);
      end
      do_start(16'h0600, 16'd0, 16'd0);
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_restart: busy=%b done=%b, required busy=1 done=0", busy, done);
      end
   endtask

   task automatic test_reset_mid_layer();
      int writes = 0;
      mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push_lane(0, 6'd0, 6'd0, 8'(8'h40 + i));
         tick();
      end
      clear_push();
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_ovf_set: overflow=%b, required 1", overflow);
      end
      do_reset();
      tests_run++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: we=%b busy=%b ovf=%b, required 000", mem_we, busy, overflow);
      end
      mem_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (mem_we === 1'b1) writes++;
         tick();
      end
      tests_run++;
      if (writes != 0) begin
         tests_failed++;
         $display("FAIL mid_no_writes: got %0d writes after reset, required 0", writes);
      end
      do_start(16'hFFF0, 16'd0, 16'h0010);
      push_lane(0, 6'd0, 6'd2, 8'h7F);
      tick();
      clear_push();
      tick();
      tests_run++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 8'h7F) begin
         tests_failed++;
         $display("FAIL addr_wrap: we=%b addr=%h data=%h, required we=1 addr=0010 data=7f",
                  mem_we, mem_addr, mem_wdata);
      end
      finish_layer("wrap");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset          = 1'b1;
      start          = 1'b0;
      drain          = 1'b0;
      mem_ready      = 1'b1;
      cfg_base_addr  = '0;
      cfg_row_stride = '0;
      cfg_col_stride = '0;
      in_valid       = '0;
      in_row         = '0;
      in_col         = '0;
      in_data        = '0;

      test_reset();
      test_single_write();
      test_round_robin();
      test_backpressure();
      test_overflow();
      test_drain_done();
      test_reset_mid_layer();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
